// File: rtl/mem_wait_bus.sv
// Clocked big-endian byte memory slave for cpu0: programmable wait states, one-cycle ready pulse,
// alignment/range error flag and a single memory-mapped 32-bit output register.
module mem_wait_bus #(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned WAIT      = 2,
  parameter logic [31:0] IO_ADDR   = 32'h0000_7000,
  parameter string       INIT_FILE = "cpu0s.hex"
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        ready,
  output logic        err,
  output logic [31:0] io_data,
  output logic        io_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [31:0] dout_q, io_q;
  logic        err_q, iov_q;
  logic [7:0]  mem [DEPTH];

  logic        accept, access;
  logic        io_hit, misalign, range_err, bad;
  logic [32:0] end_addr;
  logic [4:0]  shamt;
  logic [31:0] wfield, rfield, rdata;

  assign accept = (state_q == StIdle) && en;
  assign access = (state_q == StBusy) && (cnt_q == 4'd0);

  // Request decode works only on the latched request, never on the live bus.
  always_comb begin
    end_addr  = {1'b0, addr_q} + {31'd0, size_q} + 33'd1;
    io_hit    = (addr_q == IO_ADDR);
    misalign  = ((size_q == 2'b01) && addr_q[0]) ||
                ((size_q == 2'b11) && (addr_q[1:0] != 2'b00));
    range_err = end_addr > 33'(DEPTH);
    bad       = io_hit ? (size_q != 2'b11) : (misalign || range_err);
    shamt     = {2'd3 - size_q, 3'b000};
    wfield    = wdata_q << shamt;
    rfield    = '0;
    for (int i = 0; i < 4; i++) begin
      rfield = {rfield[23:0], mem[addr_q[AW-1:0] + AW'(i)]};
    end
    // Bytes past the field fall off the bottom; the top zero-fills.
    rdata = rfield >> shamt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StBusy;
      StBusy:  if (cnt_q == 4'd0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready    = (state_q == StDone);
    err      = ready && err_q;
    io_valid = ready && iov_q;
    dbus_out = dout_q;
    io_data  = io_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      err_q  <= 1'b0;
      iov_q  <= 1'b0;
      dout_q <= 32'd0;
      io_q   <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= abus;
        rw_q    <= rw;
        size_q  <= m_size;
        wdata_q <= dbus_in;
        cnt_q   <= 4'(WAIT);
      end else if ((state_q == StBusy) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access) begin
        err_q <= bad;
        iov_q <= !bad && io_hit && !rw_q;
        if (bad) begin
          dout_q <= 32'd0;
        end else if (rw_q) begin
          dout_q <= io_hit ? io_q : rdata;
        end
        if (!bad && io_hit && !rw_q) io_q <= wdata_q;
      end
    end
  end

  // Array is not reset; a reset on the commit edge still suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && access && !rw_q && !bad && !io_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (i <= int'(size_q)) mem[addr_q[AW-1:0] + AW'(i)] <= wfield[31-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_bus.sv
// Bench for mem_wait_bus: transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, a WAIT=0 back-to-back instance and a random phase.
module tb_mem_wait_bus;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned WAIT_A = 2;
  localparam logic [31:0] IO     = 32'h0000_7000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, rw = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [31:0] abus = 32'd0, dbus_in = 32'd0;
  logic [31:0] dout_a, iod_a, dout_b, iod_b;
  logic        rdy_a, err_a, iov_a, rdy_b, err_b, iov_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_wait_bus #(.DEPTH(DEPTH), .WAIT(WAIT_A), .IO_ADDR(IO), .INIT_FILE("")) u_dut_a (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .m_size(m_size), .abus(abus),
    .dbus_in(dbus_in), .dbus_out(dout_a), .ready(rdy_a), .err(err_a), .io_data(iod_a),
    .io_valid(iov_a)
  );

  mem_wait_bus #(.DEPTH(DEPTH), .WAIT(0), .IO_ADDR(IO), .INIT_FILE("")) u_dut_b (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .m_size(m_size), .abus(abus),
    .dbus_in(dbus_in), .dbus_out(dout_b), .ready(rdy_b), .err(err_b), .io_data(iod_b),
    .io_valid(iov_b)
  );

  task automatic chk(input string name, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model for instance A: a request is taken when the slave is free, completes
  // WAIT+1 edges later, and the slave is free again two edges after completion.
  bit   [7:0]  mem_m [DEPTH];
  logic [31:0] e_dout = 32'd0, e_io = 32'd0;
  logic        e_rdy = 1'b0, e_err = 1'b0, e_iov = 1'b0;
  bit          live = 1'b0, busy = 1'b0;
  longint      cyc = 0, due = 0, free_at = 0;
  logic        r_rw;
  logic [1:0]  r_sz;
  logic [31:0] r_a, r_d;

  always @(posedge clock) begin
    int              n;
    bit              bad;
    longint unsigned endp;
    logic [31:0]     v;
    cyc++;
    if (reset) begin
      busy = 1'b0; free_at = 0; live = 1'b1;
      e_rdy = 1'b0; e_err = 1'b0; e_iov = 1'b0; e_dout = 32'd0; e_io = 32'd0;
    end else begin
      e_rdy = 1'b0; e_err = 1'b0; e_iov = 1'b0;
      if (busy && cyc == due) begin
        n    = int'(r_sz) + 1;
        endp = longint'(r_a);
        endp = endp + longint'(n);
        if (r_a == IO) bad = (n != 4);
        else bad = (n == 2 && r_a[0]) || (n == 4 && r_a[1:0] != 2'b00) || (endp > DEPTH);
        e_rdy = 1'b1;
        if (bad) begin
          e_err = 1'b1; e_dout = 32'd0;
        end else if (r_a == IO) begin
          if (r_rw) e_dout = e_io;
          else begin e_io = r_d; e_iov = 1'b1; end
        end else if (r_rw) begin
          v = 32'd0;
          for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_m[r_a + 32'(i)]);
          e_dout = v;
        end else begin
          for (int i = 0; i < n; i++) mem_m[r_a + 32'(i)] = 8'(r_d >> (8 * (n - 1 - i)));
        end
        busy = 1'b0; free_at = cyc + 2;
      end else if (!busy && cyc >= free_at && en) begin
        r_rw = rw; r_sz = m_size; r_a = abus; r_d = dbus_in;
        busy = 1'b1; due = cyc + WAIT_A + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (live) chk("cycle_model", {rdy_a, err_a, iov_a, dout_a, iod_a},
                  {e_rdy, e_err, e_iov, e_dout, e_io});
  end

  task automatic access(input logic r, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] q,
                        output logic e, output logic v);
    @(negedge clock);
    en = 1'b1; rw = r; m_size = sz; abus = a; dbus_in = d;
    @(negedge clock);
    en = 1'b0; rw = ~r; m_size = ~sz; abus = ~a; dbus_in = ~d;
    lat = 0;
    while (!rdy_a && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("ready_seen", rdy_a, 1'b1);
    q = dout_a; e = err_a; v = iov_a;
  endtask

  logic [31:0] exp_b [3] = '{32'h0000_005A, 32'h0000_00C3, 32'h0000_007E};

  initial begin
    int          lat;
    logic [31:0] q, old;
    logic        e, v;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int a = 0; a < int'(DEPTH); a += 4) access(1'b0, 2'b11, 32'(a), $urandom, lat, q, e, v);

    access(1'b0, 2'b11, 32'd8, 32'h1122_3344, lat, q, e, v);
    chk("wr32_latency", 67'(lat), 67'd3);
    access(1'b1, 2'b11, 32'd8, 32'd0, lat, q, e, v);
    chk("rd32_latency", 67'(lat), 67'd3);
    chk("rd32_data", q, 32'h1122_3344);
    access(1'b1, 2'b00, 32'd9, 32'd0, lat, q, e, v);
    chk("rd8_data", q, 32'h0000_0022);

    access(1'b1, 2'b11, 32'd4, 32'd0, lat, q, e, v);
    old = q;
    access(1'b0, 2'b10, 32'd5, 32'hFFAA_BBCC, lat, q, e, v);
    access(1'b1, 2'b11, 32'd4, 32'd0, lat, q, e, v);
    chk("rd_after_w24", q, {old[31:24], 24'hAABBCC});

    access(1'b1, 2'b11, 32'd6, 32'd0, lat, q, e, v);
    chk("misaligned_rd32", {e, q}, {1'b1, 32'd0});
    access(1'b1, 2'b11, 32'd4, 32'd0, lat, q, e, v);
    chk("unchanged_after_misalign", q, {old[31:24], 24'hAABBCC});

    access(1'b1, 2'b00, 32'(DEPTH - 1), 32'd0, lat, q, e, v);
    old = q;
    access(1'b0, 2'b01, 32'(DEPTH - 1), 32'h0000_1234, lat, q, e, v);
    chk("range_wr16", {e, q}, {1'b1, 32'd0});
    access(1'b1, 2'b00, 32'(DEPTH - 1), 32'd0, lat, q, e, v);
    chk("unchanged_after_range", {e, q}, {1'b0, old});
    access(1'b0, 2'b10, 32'(DEPTH - 2), 32'h00AB_CDEF, lat, q, e, v);
    chk("range_wr24", e, 1'b1);
    access(1'b1, 2'b11, 32'(DEPTH - 4), 32'd0, lat, q, e, v);
    chk("last_word_ok", e, 1'b0);
    access(1'b1, 2'b11, 32'hFFFF_FFFC, 32'd0, lat, q, e, v);
    chk("no_wrap_err", {e, q}, {1'b1, 32'd0});

    access(1'b0, 2'b11, IO, 32'd55, lat, q, e, v);
    chk("io_wr", {e, v, iod_a}, {1'b0, 1'b1, 32'd55});
    access(1'b0, 2'b00, IO, 32'h0000_0077, lat, q, e, v);
    chk("io_byte_err", {e, v, iod_a}, {1'b1, 1'b0, 32'd55});
    access(1'b1, 2'b11, IO, 32'd0, lat, q, e, v);
    chk("io_rd", q, 32'd55);

    // Reset while the DEADBEEF write is still waiting.
    access(1'b1, 2'b11, 32'd0, 32'd0, lat, q, e, v);
    old = q;
    @(negedge clock);
    en = 1'b1; rw = 1'b0; m_size = 2'b11; abus = 32'd0; dbus_in = 32'hDEAD_BEEF;
    @(negedge clock);
    en = 1'b0;
    chk("busy_no_ready", rdy_a, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset_outputs", {rdy_a, err_a, iov_a, dout_a, iod_a}, 67'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("no_ready_after_reset", rdy_a, 1'b0);
    end
    access(1'b1, 2'b11, 32'd0, 32'd0, lat, q, e, v);
    chk("wr_aborted", q, old);

    // Back-to-back byte reads on the WAIT=0 instance with en held high.
    access(1'b0, 2'b00, 32'd10, 32'h0000_005A, lat, q, e, v);
    access(1'b0, 2'b00, 32'd11, 32'h0000_00C3, lat, q, e, v);
    access(1'b0, 2'b00, 32'd12, 32'h0000_007E, lat, q, e, v);
    @(negedge clock);
    en = 1'b1; rw = 1'b1; m_size = 2'b00; abus = 32'd10; dbus_in = 32'd0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      chk("b2b_ready", rdy_b, (c % 3 == 1));
      if (c % 3 == 1) chk("b2b_data", {err_b, dout_b}, {1'b0, exp_b[c / 3]});
      if (c % 3 == 0) abus = 32'(11 + c / 3);
    end
    en = 1'b0;
    repeat (8) @(negedge clock);

    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      reset   = ($urandom_range(63) == 0);
      en      = ($urandom_range(3) != 0);
      rw      = 1'($urandom);
      m_size  = 2'($urandom);
      dbus_in = $urandom;
      case ($urandom_range(7))
        0:       abus = IO;
        1:       abus = 32'hFFFF_FFFF - 32'($urandom_range(3));
        2:       abus = 32'(DEPTH - 4) + 32'($urandom_range(7));
        default: abus = 32'($urandom_range(DEPTH - 1));
      endcase
    end
    reset = 1'b0;
    en    = 1'b0;
    repeat (8) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
